// File: rtl/uart_cfg_pkg.sv
// Shared types for the configurable UART: parity encodings, FSM states, defaults.
package uart_cfg_pkg;

  localparam int OVS_DEFAULT = 16;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  function automatic logic parity_on(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// First-word-fall-through FIFO, B bits wide, 2**W entries deep.
module uart_cfg_fifo #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  logic [B-1:0] mem [2**W];
  logic [W:0]   wp, rp;
  logic         wr_en, rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[W] != rp[W]) && (wp[W-1:0] == rp[W-1:0]);
  assign rd_en = rd && !empty;
  // A read frees the slot being written, so a full FIFO still accepts rd+wr.
  assign wr_en = wr && (!full || rd_en);

  // NOTE: storage has no reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk)
    if (wr_en) mem[wp[W-1:0]] <= w_data;

  assign r_data = empty ? '0 : mem[rp[W-1:0]];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + (W+1)'(1);
      if (rd_en) rp <= rp + (W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART (divisor, parity, stop bits) with RX/TX FIFOs.
// Define UART_LOOPBACK_EN to add the loopback port (tx serializer feeds rx path).
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2,
  parameter int DVSR_W = 16,
  parameter int OVS    = OVS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   data_in,
  output logic              tx_full,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   data_out,
  output logic              rx_empty,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              clr_err
`ifdef UART_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int SW = $clog2(2*OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_HALF = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_BIT2 = SW'(2*OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  // ---------------- transmit side ----------------
  state_e            tx_state;
  logic [DBIT-1:0]   tx_sh, tx_head;
  logic [SW-1:0]     tx_s;
  logic [NW-1:0]     tx_n;
  logic [DVSR_W-1:0] tx_dv, tx_cnt;
  parity_e           tx_pm;
  logic              tx_s2, tx_par, tx_ser, tx_empty, tx_start, tx_tick;

  assign tx_start = (tx_state == IDLE) && !tx_empty;
  assign tx_tick  = (tx_dv <= DVSR_W'(1)) || (tx_cnt == tx_dv - DVSR_W'(1));

  // Each direction owns its baud counter so a frame keeps the divisor it started with.
  always_ff @(posedge clk) begin
    if (reset || tx_start || tx_tick || tx_cnt > tx_dv - DVSR_W'(1)) tx_cnt <= '0;
    else                                                              tx_cnt <= tx_cnt + DVSR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_ser   <= 1'b1;
      tx_sh    <= '0;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_dv    <= '0;
      tx_pm    <= PAR_NONE;
      tx_s2    <= 1'b0;
      tx_par   <= 1'b0;
    end else begin
      unique case (tx_state)
        IDLE: if (tx_start) begin
          tx_state <= START;
          tx_ser   <= 1'b0;
          tx_sh    <= tx_head;
          tx_par   <= (^tx_head) ^ (parity_e'(parity_mode) == PAR_ODD);
          tx_pm    <= parity_e'(parity_mode);
          tx_s2    <= stop2;
          tx_dv    <= dvsr;
          tx_s     <= '0;
        end
        START: if (tx_tick) begin
          if (tx_s == S_BIT) begin
            tx_state <= DATA;
            tx_ser   <= tx_sh[0];
            tx_s     <= '0;
            tx_n     <= '0;
          end else tx_s <= tx_s + SW'(1);
        end
        DATA: if (tx_tick) begin
          if (tx_s == S_BIT) begin
            tx_s  <= '0;
            tx_sh <= tx_sh >> 1;
            if (tx_n == N_LAST) begin
              if (parity_on(tx_pm)) begin
                tx_state <= PARITY;
                tx_ser   <= tx_par;
              end else begin
                tx_state <= STOP;
                tx_ser   <= 1'b1;
              end
            end else begin
              tx_n   <= tx_n + NW'(1);
              tx_ser <= tx_sh[1];
            end
          end else tx_s <= tx_s + SW'(1);
        end
        PARITY: if (tx_tick) begin
          if (tx_s == S_BIT) begin
            tx_state <= STOP;
            tx_ser   <= 1'b1;
            tx_s     <= '0;
          end else tx_s <= tx_s + SW'(1);
        end
        STOP: if (tx_tick) begin
          if (tx_s == (tx_s2 ? S_BIT2 : S_BIT)) tx_state <= IDLE;
          else                                  tx_s     <= tx_s + SW'(1);
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(wr_uart), .rd(tx_start), .w_data(data_in),
    .r_data(tx_head), .empty(tx_empty), .full(tx_full)
  );

  // ---------------- receive side ----------------
  state_e            rx_state;
  logic [DBIT-1:0]   rx_sh;
  logic [SW-1:0]     rx_s;
  logic [NW-1:0]     rx_n;
  logic [DVSR_W-1:0] rx_dv, rx_cnt;
  parity_e           rx_pm;
  logic              rx_s2, rx_meta, rx_sync, rx_in, rx_prev, rx_full;
  logic              rx_start, rx_tick, rx_samp, rx_push, par_det, frm_det, ovr_det;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_ser : rx_sync;
  assign tx    = loopback ? 1'b1 : tx_ser;
`else
  assign rx_in = rx_sync;
  assign tx    = tx_ser;
`endif

  always_ff @(posedge clk) begin
    if (reset) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else       {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_in};
  end

  assign rx_start = (rx_state == IDLE) && rx_prev && !rx_in;
  assign rx_tick  = (rx_dv <= DVSR_W'(1)) || (rx_cnt == rx_dv - DVSR_W'(1));
  assign rx_samp  = rx_tick && (rx_s == S_BIT);
  assign rx_push  = (rx_state == STOP) && rx_tick && (rx_s == (rx_s2 ? S_BIT2 : S_BIT));
  assign par_det  = (rx_state == PARITY) && rx_samp &&
                    (rx_in != ((^rx_sh) ^ (rx_pm == PAR_ODD)));
  assign frm_det  = (rx_state == STOP) && rx_samp && !rx_in;
  assign ovr_det  = rx_push && rx_full && !rd_uart;

  always_ff @(posedge clk) begin
    if (reset || rx_start || rx_tick || rx_cnt > rx_dv - DVSR_W'(1)) rx_cnt <= '0;
    else                                                              rx_cnt <= rx_cnt + DVSR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_sh    <= '0;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_dv    <= '0;
      rx_pm    <= PAR_NONE;
      rx_s2    <= 1'b0;
    end else begin
      unique case (rx_state)
        IDLE: if (rx_start) begin
          rx_state <= START;
          rx_pm    <= parity_e'(parity_mode);
          rx_s2    <= stop2;
          rx_dv    <= dvsr;
          rx_s     <= '0;
        end
        START: if (rx_tick) begin
          // Mid-start-bit check rejects short glitches on an idle line.
          if (rx_s == S_HALF) begin
            rx_state <= rx_in ? IDLE : DATA;
            rx_s     <= '0;
            rx_n     <= '0;
          end else rx_s <= rx_s + SW'(1);
        end
        DATA: if (rx_tick) begin
          if (rx_s == S_BIT) begin
            rx_s  <= '0;
            rx_sh <= {rx_in, rx_sh[DBIT-1:1]};
            if (rx_n == N_LAST) rx_state <= parity_on(rx_pm) ? PARITY : STOP;
            else                rx_n     <= rx_n + NW'(1);
          end else rx_s <= rx_s + SW'(1);
        end
        PARITY: if (rx_tick) begin
          if (rx_s == S_BIT) begin
            rx_state <= STOP;
            rx_s     <= '0;
          end else rx_s <= rx_s + SW'(1);
        end
        STOP: if (rx_tick) begin
          if (rx_push) rx_state <= IDLE;
          else         rx_s     <= rx_s + SW'(1);
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_push), .rd(rd_uart), .w_data(rx_sh),
    .r_data(data_out), .empty(rx_empty), .full(rx_full)
  );

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= par_det | (parity_err  & ~clr_err);
      frame_err   <= frm_det | (frame_err   & ~clr_err);
      overrun_err <= ovr_det | (overrun_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: frame-level reference model, directed and random frames.
module tb_uart_cfg;

  localparam int DBIT = 8, FIFO_W = 2, DVSR_W = 16, OVS = 16;

  logic              clk = 1'b0;
  logic              reset, rx, tx, stop2, wr_uart, tx_full, rd_uart;
  logic              rx_empty, parity_err, frame_err, overrun_err, clr_err;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        parity_mode;
  logic [DBIT-1:0]   data_in, data_out;
`ifdef UART_LOOPBACK_EN
  logic              loopback = 1'b0;
`endif

  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_cfg #(.DBIT(DBIT), .FIFO_W(FIFO_W), .DVSR_W(DVSR_W), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .dvsr(dvsr), .parity_mode(parity_mode),
    .stop2(stop2), .wr_uart(wr_uart), .data_in(data_in), .tx_full(tx_full),
    .rd_uart(rd_uart), .data_out(data_out), .rx_empty(rx_empty), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .clr_err(clr_err)
`ifdef UART_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  // Clocks per serial bit for the current divisor.
  function automatic int bit_clk();
    return ((dvsr <= 1) ? 1 : int'(dvsr)) * OVS;
  endfunction

  // Line levels of one frame, LSB first: start, data, optional parity, stop bit(s).
  function automatic int build_frame(input logic [DBIT-1:0] d, input logic [1:0] pm,
                                     input logic s2, output logic [15:0] f);
    int n, ones;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DBIT; i++) f[1+i] = d[i];
    n = 1 + DBIT;
    ones = $countones(d);
    if (pm == 2'b01 || pm == 2'b10) begin
      f[n] = (pm == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      n++;
    end
    return n + (s2 ? 2 : 1);
  endfunction

  task automatic wr_byte(input logic [DBIT-1:0] d);
    @(negedge clk); wr_uart = 1'b1; data_in = d;
    @(negedge clk); wr_uart = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk); rd_uart = 1'b1;
    @(negedge clk); rd_uart = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  // Waits for a start bit on tx, then samples each bit at its centre.
  task automatic capture_tx(input int nbits, output logic [15:0] got, output int fall_cyc,
                            output bit ok);
    int w = 0;
    int bt = bit_clk();
    got = '1; ok = 1'b1; fall_cyc = 0;
    while (tx !== 1'b0 && w < 5000) begin @(negedge clk); w++; end
    if (tx !== 1'b0) begin ok = 1'b0; return; end
    fall_cyc = cyc;
    repeat (bt/2) @(negedge clk);
    got[0] = tx;
    for (int i = 1; i < nbits; i++) begin repeat (bt) @(negedge clk); got[i] = tx; end
  endtask

  task automatic drive_rx(input logic [DBIT-1:0] d, input logic [1:0] pm, input logic s2,
                          input bit bad_par, input bit bad_stop);
    logic [15:0] f;
    int n;
    int bt = bit_clk();
    n = build_frame(d, pm, s2, f);
    if (bad_par) f[1+DBIT] = ~f[1+DBIT];
    if (bad_stop) f[n - (s2 ? 2 : 1)] = 1'b0;
    for (int i = 0; i < n; i++) begin rx = f[i]; repeat (bt) @(negedge clk); end
    rx = 1'b1;
    repeat (bt) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0;
    data_in = '0; dvsr = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
    total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL rst_tx_full: got %b want 0", tx_full); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rst_rx_empty: got %b want 1", rx_empty); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data_out: got %h want 00", data_out); end
    total++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: got %b want 000", {parity_err, frame_err, overrun_err});
    end
  endtask

  task automatic test_tx_a5();
    logic [15:0] f;
    int w = 0, low = 0, n;
    dvsr = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    n = build_frame(8'hA5, 2'b00, 1'b0, f);
    wr_byte(8'hA5);
    while (tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    while (tx === 1'b0 && low < 2000) begin @(negedge clk); low++; end
    total++; if (low != 64) begin bad++; $display("FAIL a5_start_len: got %0d clk want 64", low); end
    repeat (32) @(negedge clk);
    for (int i = 1; i < n; i++) begin
      total++; if (tx !== f[i]) begin bad++; $display("FAIL a5_bit%0d: got %b want %b", i, tx, f[i]); end
      if (i < n-1) repeat (64) @(negedge clk);
    end
  endtask

  task automatic test_tx_frames();
    logic [15:0] f, got;
    logic [DBIT-1:0] d;
    int n, fc;
    bit ok;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin d = '0; parity_mode = 2'b10; stop2 = 1'b1; dvsr = 16'd4; end
      else begin
        d = DBIT'($urandom); parity_mode = 2'($urandom); stop2 = 1'($urandom);
        dvsr = DVSR_W'($urandom_range(0, 3));
      end
      n = build_frame(d, parity_mode, stop2, f);
      wr_byte(d);
      capture_tx(n, got, fc, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL tx_frame%0d: no start bit within bound", it); end
      else if (got !== f) begin
        bad++; $display("FAIL tx_frame%0d: got %b want %b (d=%h pm=%b s2=%b)", it, got, f, d, parity_mode, stop2);
      end
      repeat (bit_clk()) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [DBIT-1:0] b [6];
    logic [15:0] got [5];
    logic [15:0] f;
    int fc [5];
    bit okv [5];
    int n, w;
    dvsr = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 6; i++) b[i] = DBIT'($urandom);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 5) begin
            total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL b2b_tx_full: got %b want 1", tx_full); end
          end
          wr_uart = 1'b1; data_in = b[i];
        end
        @(negedge clk); wr_uart = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) capture_tx(10, got[k], fc[k], okv[k]);
      end
    join
    for (int k = 0; k < 5; k++) begin
      n = build_frame(b[k], 2'b00, 1'b0, f);
      total++;
      if (!okv[k] || got[k] !== f) begin
        bad++; $display("FAIL b2b_frame%0d: got %b want %b ok=%0d", k, got[k], f, okv[k]);
      end
      if (k > 0) begin
        total++;
        if (fc[k] - fc[k-1] < 10*32 || fc[k] - fc[k-1] > 10*32 + 1) begin
          bad++; $display("FAIL b2b_gap%0d: got %0d clk want 320..321", k, fc[k] - fc[k-1]);
        end
      end
    end
    w = 0;
    while (tx === 1'b1 && w < 700) begin @(negedge clk); w++; end
    total++; if (w != 700) begin bad++; $display("FAIL b2b_sixth_ignored: extra frame after %0d clk", w); end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    dvsr = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    while (tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
    repeat (320 + 100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL rstmid_tx_full: got %b want 0", tx_full); end
    w = 0;
    while (tx === 1'b1 && w < 700) begin @(negedge clk); w++; end
    total++; if (w != 700) begin bad++; $display("FAIL rstmid_fifo_empty: frame started after %0d clk", w); end
  endtask

  task automatic test_rx_parity();
    dvsr = 16'd4; parity_mode = 2'b01; stop2 = 1'b0;
    drive_rx(8'h03, 2'b01, 1'b0, 1'b1, 1'b0);
    total++; if (data_out !== 8'h03) begin bad++; $display("FAIL par_data: got %h want 03", data_out); end
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_set: got %b want 1", parity_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL par_no_frame: got %b want 0", frame_err); end
    clr_pulse();
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_clr: got %b want 0", parity_err); end
    rd_pulse();
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL par_rx_empty: got %b want 1", rx_empty); end
  endtask

  task automatic test_rx_frame_glitch();
    dvsr = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    drive_rx(8'h55, 2'b00, 1'b0, 1'b0, 1'b1);
    total++; if (data_out !== 8'h55 || rx_empty !== 1'b0) begin
      bad++; $display("FAIL frm_data: got %h empty=%b want 55 empty=0", data_out, rx_empty);
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frm_err_set: got %b want 1", frame_err); end
    clr_pulse(); rd_pulse();
    @(negedge clk); rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (800) @(negedge clk);
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_no_byte: rx_empty got %b want 1", rx_empty); end
    total++; if ({parity_err, frame_err} !== 2'b00) begin
      bad++; $display("FAIL glitch_flags: got %b want 00", {parity_err, frame_err});
    end
  endtask

  task automatic test_overrun();
    logic [DBIT-1:0] b [5];
    dvsr = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b[i] = DBIT'($urandom);
      drive_rx(b[i], 2'b00, 1'b0, 1'b0, 1'b0);
      if (i == 3) begin
        total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", overrun_err); end
      end
    end
    total++; if (overrun_err !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun_err); end
    for (int i = 0; i < 4; i++) begin
      total++; if (data_out !== b[i] || rx_empty !== 1'b0) begin
        bad++; $display("FAIL ovr_read%0d: got %h empty=%b want %h", i, data_out, rx_empty, b[i]);
      end
      rd_pulse();
    end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL ovr_drained: rx_empty got %b want 1", rx_empty); end
    clr_pulse();
  endtask

  task automatic test_rx_random();
    logic [DBIT-1:0] q [$];
    logic [DBIT-1:0] d, exp;
    bit bp, bs, exp_pe, exp_fe;
    int k;
    for (int it = 0; it < 6; it++) begin
      dvsr = DVSR_W'($urandom_range(0, 4)); parity_mode = 2'($urandom); stop2 = 1'($urandom);
      k = $urandom_range(1, 3);
      exp_pe = 1'b0; exp_fe = 1'b0;
      for (int j = 0; j < k; j++) begin
        d = DBIT'($urandom);
        bp = (parity_mode == 2'b01 || parity_mode == 2'b10) && ($urandom_range(0, 1) == 1);
        bs = ($urandom_range(0, 3) == 0);
        exp_pe |= bp; exp_fe |= bs;
        q.push_back(d);
        drive_rx(d, parity_mode, stop2, bp, bs);
      end
      total++; if (parity_err !== exp_pe || frame_err !== exp_fe) begin
        bad++; $display("FAIL rnd%0d_flags: got pe=%b fe=%b want pe=%b fe=%b", it, parity_err, frame_err, exp_pe, exp_fe);
      end
      while (q.size() > 0) begin
        exp = q.pop_front();
        total++; if (data_out !== exp || rx_empty !== 1'b0) begin
          bad++; $display("FAIL rnd%0d_data: got %h empty=%b want %h", it, data_out, rx_empty, exp);
        end
        rd_pulse();
      end
      total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rnd%0d_empty: got %b want 1", it, rx_empty); end
      clr_pulse();
    end
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_tx_frames();
    test_back_to_back();
    test_reset_mid();
    test_rx_parity();
    test_rx_frame_glitch();
    test_overrun();
    test_rx_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
